// File: rtl/hybrid_gate_sequencer.sv
// Gate sequencer between the hybrid control law and the half-bridge drivers.
// Optional RUN commit counter is built when HYBRID_SEQ_JUMP_COUNTER_EN is defined.
module hybrid_gate_sequencer #(
    parameter int DEADTIME        = 20,
    parameter int MIN_DWELL       = 200,
    parameter int STARTUP_HALF    = 500,
    parameter int STARTUP_TOGGLES = 8
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_enable,
    input  logic        i_fault,
    input  logic        i_sigma,
    output logic        o_sigma,
    output logic        o_gate_H,
    output logic        o_gate_L,
    output logic        o_closed_loop,
    output logic [1:0]  o_state,
    output logic [15:0] o_jump_count
);

    localparam int DT_W   = $clog2(DEADTIME + 1);
    localparam int DW_W   = $clog2(MIN_DWELL + 1);
    localparam int HALF_W = $clog2(STARTUP_HALF + 1);
    localparam int TG_W   = $clog2(STARTUP_TOGGLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sig_q;
    logic                sigma_q, sigma_d;
    logic [DT_W-1:0]     dt_q, dt_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [TG_W-1:0]     tog_q, tog_d;
    logic                do_commit;
    logic                commit_val;
    logic                active;

    always_comb begin
        state_d    = state_q;
        sigma_d    = sigma_q;
        dt_d       = (dt_q == '0) ? '0 : dt_q - DT_W'(1);
        dwell_d    = (dwell_q == '0) ? '0 : dwell_q - DW_W'(1);
        half_d     = (half_q == '0) ? '0 : half_q - HALF_W'(1);
        tog_d      = tog_q;
        do_commit  = 1'b0;
        commit_val = sigma_q;

        if (i_fault) begin
            state_d = ST_FAULT;
        end else if (!i_enable) begin
            // Covers the FAULT exit too: it needs fault and enable both low.
            state_d = ST_IDLE;
            sigma_d = 1'b0;
            dt_d    = '0;
            dwell_d = '0;
            half_d  = '0;
            tog_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_STARTUP;
                    do_commit  = 1'b1;
                    commit_val = 1'b1;
                    half_d     = HALF_W'(STARTUP_HALF);
                    tog_d      = '0;
                end
                ST_STARTUP: begin
                    if (half_q == HALF_W'(1)) begin
                        if (tog_q == TG_W'(STARTUP_TOGGLES - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            do_commit  = 1'b1;
                            commit_val = ~sigma_q;
                            half_d     = HALF_W'(STARTUP_HALF);
                            tog_d      = tog_q + TG_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    // The commit may land on the edge where the dwell counter reaches 0.
                    if ((sig_q != sigma_q) && (dwell_q <= DW_W'(1))) begin
                        do_commit  = 1'b1;
                        commit_val = sig_q;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end

        if (do_commit) begin
            sigma_d = commit_val;
            dt_d    = DT_W'(DEADTIME);
            dwell_d = DW_W'(MIN_DWELL);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            state_q <= ST_IDLE;
            sig_q   <= 1'b0;
            sigma_q <= 1'b0;
            dt_q    <= '0;
            dwell_q <= '0;
            half_q  <= '0;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= i_sigma;
            sigma_q <= sigma_d;
            dt_q    <= dt_d;
            dwell_q <= dwell_d;
            half_q  <= half_d;
            tog_q   <= tog_d;
        end
    end

    // Gates derive only from registered state, so they can never overlap.
    assign active        = (state_q == ST_STARTUP) || (state_q == ST_RUN);
    assign o_gate_H      = active && (dt_q == '0) && sigma_q;
    assign o_gate_L      = active && (dt_q == '0) && !sigma_q;
    assign o_sigma       = sigma_q;
    assign o_closed_loop = (state_q == ST_RUN);
    assign o_state       = state_q;

`ifdef HYBRID_SEQ_JUMP_COUNTER_EN
    logic [15:0] jump_q;
    logic        run_commit;
    logic        startup_entry;

    assign run_commit    = (state_q == ST_RUN) && do_commit;
    assign startup_entry = (state_q == ST_IDLE) && (state_d == ST_STARTUP);

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            jump_q <= '0;
        end else if (startup_entry) begin
            jump_q <= '0;
        end else if (run_commit && (jump_q != 16'hFFFF)) begin
            jump_q <= jump_q + 16'd1;
        end
    end

    assign o_jump_count = jump_q;
`else
    assign o_jump_count = 16'd0;
`endif

endmodule
